// File: rtl/micro_sequencer_if.sv
//------------------------------------------------------------------------------
// micro_sequencer_if : sequencer <-> control-store / datapath signal bundle
// Optional retire_cnt signal present when USEQ_RETIRE_CNT_EN is defined.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface micro_sequencer_if #(
    parameter int RETIRE_W = 32
);
    logic [2:0]          seq_ctl;
    logic [6:0]          opcode;
    logic                mem_wait;
    logic                restart;
    logic [3:0]          upc;
    logic                kill;
    logic                illegal;
    logic                instr_done;
`ifdef USEQ_RETIRE_CNT_EN
    logic [RETIRE_W-1:0] retire_cnt;

    modport master (
        input  seq_ctl, opcode, mem_wait, restart,
        output upc, kill, illegal, instr_done, retire_cnt
    );

    modport slave (
        output seq_ctl, opcode, mem_wait, restart,
        input  upc, kill, illegal, instr_done, retire_cnt
    );
`else
    modport master (
        input  seq_ctl, opcode, mem_wait, restart,
        output upc, kill, illegal, instr_done
    );

    modport slave (
        output seq_ctl, opcode, mem_wait, restart,
        input  upc, kill, illegal, instr_done
    );
`endif
endinterface

`default_nettype wire

// File: rtl/micro_sequencer.sv
//------------------------------------------------------------------------------
// micro_sequencer : 4-bit micro-PC sequencer with opcode dispatch and halt trap
// Optional retired-instruction counter enabled by USEQ_RETIRE_CNT_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module micro_sequencer #(
    parameter logic [3:0] FETCH_ADDR = 4'd0,
    parameter logic [3:0] ALUWB_ADDR = 4'd7,
    parameter logic [3:0] HALT_ADDR  = 4'd15,
    parameter int         RETIRE_W   = 32
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    micro_sequencer_if.master  bus
);

    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_itype  = 7'b0010011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_branch = 7'b1100011;

    localparam logic [3:0] c_upc_memaddr = 4'd2;
    localparam logic [3:0] c_upc_memrd   = 4'd3;
    localparam logic [3:0] c_upc_memwr   = 4'd5;
    localparam logic [3:0] c_upc_exec_r  = 4'd6;
    localparam logic [3:0] c_upc_exec_i  = 4'd8;
    localparam logic [3:0] c_upc_jal     = 4'd9;
    localparam logic [3:0] c_upc_branch  = 4'd10;

    localparam logic [2:0] c_seq_next  = 3'b000;
    localparam logic [2:0] c_seq_disp1 = 3'b001;
    localparam logic [2:0] c_seq_disp2 = 3'b010;
    localparam logic [2:0] c_seq_fetch = 3'b011;
    localparam logic [2:0] c_seq_aluwb = 3'b100;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_upc;
    logic [3:0] w_upc_nxt;
    logic       r_illegal;
    logic       w_illegal_nxt;
    logic       r_done;
    logic       w_done_nxt;
    logic       w_stall;
    logic [3:0] w_disp1_addr;
    logic       w_disp1_ok;
    logic [3:0] w_disp2_addr;
    logic       w_disp2_ok;

    // Dispatch tables; an unmatched opcode traps into HALT.
    always_comb begin
        w_disp1_addr = FETCH_ADDR;
        w_disp1_ok   = 1'b1;
        case (bus.opcode)
            c_op_load,
            c_op_store:  w_disp1_addr = c_upc_memaddr;
            c_op_rtype:  w_disp1_addr = c_upc_exec_r;
            c_op_itype:  w_disp1_addr = c_upc_exec_i;
            c_op_jal:    w_disp1_addr = c_upc_jal;
            c_op_branch: w_disp1_addr = c_upc_branch;
            default:     w_disp1_ok   = 1'b0;
        endcase
    end

    always_comb begin
        w_disp2_addr = FETCH_ADDR;
        w_disp2_ok   = 1'b1;
        case (bus.opcode)
            c_op_load:  w_disp2_addr = c_upc_memrd;
            c_op_store: w_disp2_addr = c_upc_memwr;
            default:    w_disp2_ok   = 1'b0;
        endcase
    end

    // Only the Fetch and memory-access micro-states wait on memory.
    assign w_stall = bus.mem_wait &&
                     ((r_upc == FETCH_ADDR) || (r_upc == c_upc_memrd) ||
                      (r_upc == c_upc_memwr));

    always_comb begin
        w_state_nxt   = r_state;
        w_upc_nxt     = r_upc;
        w_illegal_nxt = r_illegal;
        w_done_nxt    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (!w_stall) begin
                    case (bus.seq_ctl)
                        c_seq_next: w_upc_nxt = r_upc + 4'd1;
                        c_seq_disp1: begin
                            if (w_disp1_ok) begin
                                w_upc_nxt = w_disp1_addr;
                            end else begin
                                w_state_nxt = ST_HALT;
                            end
                        end
                        c_seq_disp2: begin
                            if (w_disp2_ok) begin
                                w_upc_nxt = w_disp2_addr;
                            end else begin
                                w_state_nxt = ST_HALT;
                            end
                        end
                        c_seq_fetch: begin
                            w_upc_nxt  = FETCH_ADDR;
                            w_done_nxt = 1'b1;
                        end
                        c_seq_aluwb: w_upc_nxt   = ALUWB_ADDR;
                        default:     w_state_nxt = ST_HALT;
                    endcase
                    if (w_state_nxt == ST_HALT) begin
                        w_upc_nxt     = HALT_ADDR;
                        w_illegal_nxt = 1'b1;
                    end
                end
            end
            ST_HALT: begin
                if (bus.restart) begin
                    w_state_nxt = ST_RUN;
                    w_upc_nxt   = FETCH_ADDR;
                end
            end
            default: begin
                w_state_nxt = ST_HALT;
                w_upc_nxt   = HALT_ADDR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_upc     <= FETCH_ADDR;
            r_illegal <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_upc     <= w_upc_nxt;
            r_illegal <= w_illegal_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign bus.upc        = r_upc;
    assign bus.kill       = (r_state == ST_HALT);
    assign bus.illegal    = r_illegal;
    assign bus.instr_done = r_done;

`ifdef USEQ_RETIRE_CNT_EN
    logic [RETIRE_W-1:0] r_retire;

    // Advances on the same edge that raises instr_done, so the count tracks the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire <= '0;
        end else if (w_done_nxt) begin
            r_retire <= r_retire + {{(RETIRE_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.retire_cnt = r_retire;
`endif

endmodule

`default_nettype wire

// File: tb/tb_micro_sequencer.sv
//------------------------------------------------------------------------------
// tb_micro_sequencer : directed stimulus, per-cycle model compare, literal pins
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_micro_sequencer;

    logic clk;
    logic rst_n;

    micro_sequencer_if #(.RETIRE_W(32)) bus ();

    micro_sequencer #(
        .FETCH_ADDR (4'd0),
        .ALUWB_ADDR (4'd7),
        .HALT_ADDR  (4'd15),
        .RETIRE_W   (32)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: micro-program semantics expressed as address arithmetic.
    bit          m_halt;
    int          m_upc;
    bit          m_illegal;
    bit          m_done;
    logic [31:0] m_cnt;
    int          m_tgt;

    function automatic int disp1(input logic [6:0] op);
        if (op == 7'b0000011 || op == 7'b0100011) return 2;
        if (op == 7'b0110011) return 6;
        if (op == 7'b0010011) return 8;
        if (op == 7'b1101111) return 9;
        if (op == 7'b1100011) return 10;
        return -1;
    endfunction

    function automatic int disp2(input logic [6:0] op);
        if (op == 7'b0000011) return 3;
        if (op == 7'b0100011) return 5;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_halt = 0; m_upc = 0; m_illegal = 0; m_done = 0; m_cnt = 0;
        end else begin
            m_done = 0;
            if (m_halt) begin
                if (bus.restart) begin
                    m_halt = 0;
                    m_upc  = 0;
                end
            end else if (!(bus.mem_wait && (m_upc == 0 || m_upc == 3 || m_upc == 5))) begin
                case (bus.seq_ctl)
                    3'd0:    m_tgt = m_upc + 1;
                    3'd1:    m_tgt = disp1(bus.opcode);
                    3'd2:    m_tgt = disp2(bus.opcode);
                    3'd3:    begin m_tgt = 0; m_done = 1; m_cnt = m_cnt + 1; end
                    3'd4:    m_tgt = 7;
                    default: m_tgt = -1;
                endcase
                if (m_tgt < 0) begin
                    m_halt = 1; m_illegal = 1; m_upc = 15;
                end else begin
                    m_upc = m_tgt;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("model_upc", {28'd0, bus.upc}, m_upc);
        chk("model_kill", {31'd0, bus.kill}, {31'd0, m_halt});
        chk("model_illegal", {31'd0, bus.illegal}, {31'd0, m_illegal});
        chk("model_instr_done", {31'd0, bus.instr_done}, {31'd0, m_done});
`ifdef USEQ_RETIRE_CNT_EN
        chk("model_retire_cnt", bus.retire_cnt, m_cnt);
`endif
    end

    // Apply one cycle of inputs, then pin the resulting micro-address.
    task automatic step(input string name, input logic [2:0] s, input logic [6:0] op,
                        input logic mw, input logic rs, input int exp_upc);
        bus.seq_ctl  = s;
        bus.opcode   = op;
        bus.mem_wait = mw;
        bus.restart  = rs;
        @(posedge clk);
        #1;
        chk(name, {28'd0, bus.upc}, exp_upc);
    endtask

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    initial begin
        rst_n = 1'b0;
        bus.seq_ctl = 3'd0; bus.opcode = 7'd0; bus.mem_wait = 1'b0; bus.restart = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_upc", {28'd0, bus.upc}, 32'd0);
        chk("reset_kill", {31'd0, bus.kill}, 32'd0);
        chk("reset_illegal", {31'd0, bus.illegal}, 32'd0);
        chk("reset_done", {31'd0, bus.instr_done}, 32'd0);
        rst_n = 1'b1;

        // lw, no wait
        step("lw_fetch",  3'd0, OP_LW, 1'b0, 1'b0, 1);
        chk("no_done_after_reset", {31'd0, bus.instr_done}, 32'd0);
        step("lw_decode", 3'd1, OP_LW, 1'b0, 1'b0, 2);
        step("lw_maddr",  3'd2, OP_LW, 1'b0, 1'b0, 3);
        step("lw_mrd",    3'd0, OP_LW, 1'b0, 1'b0, 4);
        step("lw_wb",     3'd3, OP_LW, 1'b0, 1'b0, 0);
        chk("lw_done", {31'd0, bus.instr_done}, 32'd1);
`ifdef USEQ_RETIRE_CNT_EN
        chk("lw_retire", bus.retire_cnt, 32'd1);
`endif

        // sw with two wait cycles in the write state
        step("sw_fetch",  3'd0, OP_SW, 1'b0, 1'b0, 1);
        chk("done_one_cycle", {31'd0, bus.instr_done}, 32'd0);
        step("sw_decode", 3'd1, OP_SW, 1'b1, 1'b0, 2);
        step("sw_maddr",  3'd2, OP_SW, 1'b1, 1'b0, 5);
        step("sw_wait1",  3'd3, OP_SW, 1'b1, 1'b0, 5);
        chk("sw_wait_kill", {31'd0, bus.kill}, 32'd0);
        step("sw_wait2",  3'd3, OP_SW, 1'b1, 1'b0, 5);
        step("sw_mwr",    3'd3, OP_SW, 1'b0, 1'b0, 0);
        chk("sw_done", {31'd0, bus.instr_done}, 32'd1);

        // Fetch stall
        step("fetch_stall", 3'd0, OP_R, 1'b1, 1'b0, 0);
        chk("stall_no_done", {31'd0, bus.instr_done}, 32'd0);

        // R-type then beq
        step("r_fetch",  3'd0, OP_R,   1'b0, 1'b0, 1);
        step("r_decode", 3'd1, OP_R,   1'b0, 1'b0, 6);
        step("r_exec",   3'd4, OP_R,   1'b0, 1'b0, 7);
        step("r_wb",     3'd3, OP_R,   1'b0, 1'b0, 0);
        step("b_fetch",  3'd0, OP_BEQ, 1'b0, 1'b0, 1);
        step("b_decode", 3'd1, OP_BEQ, 1'b0, 1'b0, 10);
        step("b_exec",   3'd3, OP_BEQ, 1'b0, 1'b0, 0);
`ifdef USEQ_RETIRE_CNT_EN
        chk("retire_after_4", bus.retire_cnt, 32'd4);
`endif

        // I-type and jal dispatch; restart while running is ignored
        step("i_fetch",  3'd0, OP_I,   1'b0, 1'b1, 1);
        step("i_decode", 3'd1, OP_I,   1'b0, 1'b0, 8);
        step("i_exec",   3'd4, OP_I,   1'b0, 1'b0, 7);
        step("i_wb",     3'd3, OP_I,   1'b0, 1'b0, 0);
        step("j_fetch",  3'd0, OP_JAL, 1'b0, 1'b0, 1);
        step("j_decode", 3'd1, OP_JAL, 1'b0, 1'b0, 9);
        step("j_exec",   3'd3, OP_JAL, 1'b0, 1'b0, 0);

        // Unsupported opcode at decode traps
        step("bad_fetch",  3'd0, OP_BAD, 1'b0, 1'b0, 1);
        step("bad_decode", 3'd1, OP_BAD, 1'b0, 1'b0, 15);
        chk("halt_kill", {31'd0, bus.kill}, 32'd1);
        chk("halt_illegal", {31'd0, bus.illegal}, 32'd1);
        chk("halt_no_done", {31'd0, bus.instr_done}, 32'd0);
        step("halt_hold1", 3'd3, OP_LW, 1'b1, 1'b0, 15);
        step("halt_hold2", 3'd0, OP_LW, 1'b0, 1'b0, 15);
        step("halt_hold3", 3'd1, OP_SW, 1'b1, 1'b0, 15);
        step("restart",    3'd7, OP_BAD, 1'b1, 1'b1, 0);
        chk("restart_kill", {31'd0, bus.kill}, 32'd0);
        chk("restart_illegal", {31'd0, bus.illegal}, 32'd1);

        // Corrupt sequencing field
        step("c_fetch",   3'd0, OP_LW, 1'b0, 1'b0, 1);
        step("c_corrupt", 3'd6, OP_LW, 1'b0, 1'b0, 15);
        chk("corrupt_kill", {31'd0, bus.kill}, 32'd1);
        step("c_restart", 3'd0, OP_LW, 1'b0, 1'b1, 0);

        // Dispatch-2 miss traps
        step("d2_fetch",  3'd0, OP_R, 1'b0, 1'b0, 1);
        step("d2_decode", 3'd1, OP_R, 1'b0, 1'b0, 6);
        step("d2_bad",    3'd2, OP_R, 1'b0, 1'b0, 15);
        step("d2_restart",3'd0, OP_R, 1'b0, 1'b1, 0);

        // Async reset in the middle of a stalled load read
        step("rs_fetch",  3'd0, OP_LW, 1'b0, 1'b0, 1);
        step("rs_decode", 3'd1, OP_LW, 1'b0, 1'b0, 2);
        step("rs_maddr",  3'd2, OP_LW, 1'b0, 1'b0, 3);
        step("rs_stall",  3'd0, OP_LW, 1'b1, 1'b0, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_upc", {28'd0, bus.upc}, 32'd0);
        chk("async_illegal", {31'd0, bus.illegal}, 32'd0);
        chk("async_done", {31'd0, bus.instr_done}, 32'd0);
        chk("async_kill", {31'd0, bus.kill}, 32'd0);
`ifdef USEQ_RETIRE_CNT_EN
        chk("async_retire", bus.retire_cnt, 32'd0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        step("post_fetch",  3'd0, OP_LW, 1'b0, 1'b0, 1);
        step("post_decode", 3'd1, OP_SW, 1'b0, 1'b0, 2);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Microprogram sequencer for the multicycle RISC-V core. Holds the 4-bit micro-PC that addresses the microcode control store.
- Computes the next micro-address from the store's 3-bit sequencing field, the instruction opcode (two dispatch tables) and the memory wait handshake.
- Traps unsupported opcodes into a halt state and reports instruction retirement.

Parameters:
- FETCH_ADDR, 4'd0, micro-address of the Fetch state
- ALUWB_ADDR, 4'd7, micro-address of the ALU write-back state
- HALT_ADDR, 4'd15, micro-address driven while halted (outside the populated store)
- RETIRE_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- seq_ctl  in  3  sequencing field, control-store output bits [2:0]
- opcode  in  7  instr[6:0] from the instruction register
- mem_wait  in  1  memory not ready; stalls memory micro-states
- restart  in  1  leave halt and resume at Fetch
- upc  out  4  micro-address to the control store
- kill  out  1  squash all datapath write enables (high while halted)
- illegal  out  1  sticky illegal-opcode flag
- instr_done  out  1  one-cycle pulse when an instruction completes
- retire_cnt  out  RETIRE_W  retired-instruction count (optional feature only)

Behaviour:
- Reset (async, rst_n=0): upc=FETCH_ADDR, kill=0, illegal=0, instr_done=0, retire_cnt=0. Reset during any state, including mid-access or halt, aborts immediately.
- Registered upc. Next value is applied on the rising clk edge; control-store output is valid in the same cycle.
- Two modes: RUN and HALT.
- RUN, no stall, seq_ctl decode:
  - 000: upc+1
  - 001: dispatch 1, keyed on opcode:
    - 0000011 or 0100011 -> 2
    - 0110011 -> 6
    - 0010011 -> 8
    - 1101111 -> 9
    - 1100011 -> 10
    - any other opcode -> HALT
  - 010: dispatch 2, keyed on opcode:
    - 0000011 -> 3
    - 0100011 -> 5
    - any other opcode -> HALT
  - 011: FETCH_ADDR; instruction completes
  - 100: ALUWB_ADDR
  - 101-111: HALT with illegal=1 (corrupt microcode)
- Stall: mem_wait=1 while upc is 0, 3 or 5 holds upc unchanged. mem_wait is ignored in all other states and has no effect on kill.
- Entering HALT: upc=HALT_ADDR, kill=1 and illegal=1, both from the first HALT cycle.
- In HALT:
  - seq_ctl, opcode and mem_wait are ignored (the store output at 15 is undefined).
  - restart=1 -> RUN at FETCH_ADDR next cycle, kill=0. illegal stays set until reset.
  - restart in RUN is ignored.
- instr_done: registered, high for exactly the cycle after a seq_ctl=011 transition, i.e. the first Fetch cycle of the next instruction. Never asserted on halt entry or on reset exit.
- upc+1 from 15 never occurs (15 is reachable only in HALT).

Optional Feature:
- Macro: USEQ_RETIRE_CNT_EN.
- Defined: retire_cnt port present. Increments by 1 on every instr_done pulse, wraps modulo 2^RETIRE_W, holds while halted, resets to 0.
- Undefined: no retire_cnt port and no counter logic; all other behaviour is identical.

Test Plan:
- lw (opcode 0000011), mem_wait=0 -> upc 0,1,2,3,4,0 on consecutive cycles; instr_done high in the cycle upc returns to 0; retire_cnt 0->1.
- sw (0100011), mem_wait=1 for 2 cycles in state 5 -> upc 0,1,2,5,5,5,0; kill=0 throughout.
- R-type 0110011 then beq 1100011 -> upc 0,1,6,7,0,1,10,0; two instr_done pulses; retire_cnt=2.
- Opcode 1111111 at Decode -> next upc=15, kill=1, illegal=1; mem_wait toggling has no effect. restart=1 -> upc=0, kill=0, illegal still 1.
- seq_ctl=110 forced in state 1 -> HALT, illegal=1.
- rst_n low mid state 3 with mem_wait=1 -> upc=0 asynchronously; illegal, instr_done and retire_cnt all 0. Release -> normal fetch resumes.
